fifo_push_arb: RTL and testbench
================================

Name: fifo_push_arb

Overview:
- Round-robin arbiter sharing the single push port of the parameterized FIFO between n_req producers.
- Tracks FIFO occupancy with its own credit counter, so a grant never overflows the FIFO despite the registered push stage.
- Sits directly in front of FIFO (push_i/push_data_i); the consumer drives FIFO pop_i, which the arbiter also observes.

Parameters:
- data_w, 8, payload width; must match FIFO data_w.
- depth, 4, FIFO entries; must match FIFO depth.
- n_req, 4, number of requesters (>=2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_i  in  n_req  per-requester push request.
- req_data_i  in  n_req*data_w  payload; requester k in bits [k*data_w +: data_w].
- gnt_o  out  n_req  one-hot grant, combinational; the request is accepted at the clock edge where it is high.
- push_o  out  1  registered push to FIFO push_i.
- push_data_o  out  data_w  registered payload to FIFO push_data_i.
- fifo_pop_i  in  1  copy of the FIFO pop_i.
- fifo_e_i  in  1  FIFO e_o.
- fifo_f_i  in  1  FIFO f_o.
- occ_o  out  $clog2(depth+1)  credit count: entries in FIFO plus in-flight push.
- ovf_o  out  1  sticky error flag.

Behaviour:
- Reset values: push_o=0, push_data_o=0, occ_o=0, ovf_o=0, rr pointer=n_req-1 (requester 0 wins first). gnt_o=0 while reset is asserted.
- Handshake:
  - Requester holds req_i and data stable until it sees gnt_o high, then may drop or change them.
  - One grant per cycle.
  - gnt_o is never asserted to a requester with req_i=0.
- Grant condition: any req_i high AND occ_o < depth.
  - Winner is the first requesting index searching upward from ptr+1, wrapping modulo n_req.
- On grant edge:
  - push_o<=1 and push_data_o<=winner data.
  - ptr<=winner. ptr is unchanged when there is no grant.
- Without a grant, push_o<=0 and push_data_o holds its value.
- Latency: request accepted at edge N; FIFO push happens at edge N+1.
- Credit: pop_ok = fifo_pop_i & ~fifo_e_i. Next occ = occ + grant − pop_ok.
  - Simultaneous grant and pop_ok: occ unchanged.
  - occ never exceeds depth and never goes below 0.
- Full: with occ=depth, no grant is issued, even if fifo_f_i=0 because the push is still in flight.
  - A pop at occ=depth re-enables grants on the next cycle, not the same cycle.
- Empty pop: with FIFO empty and occ=1 (push in flight), pop_ok=0, so no decrement.
- ovf_o: set when push_o & fifo_f_i & ~fifo_pop_i at a clock edge, or when pop_ok=1 with occ=0. It is sticky and cleared only by reset.
- Reset mid-operation:
  - Any in-flight push is dropped and all state returns to reset values.
  - The FIFO must be reset in the same cycle; the two share one reset domain.

Optional Feature:
- Macro FIFO_ARB_LOCK_EN.
- Defined:
  - Adds input lock_i [n_req].
  - While the last-granted requester keeps req_i=1 and lock_i=1, it is granted again in preference to round-robin, subject to credit. Its contiguous bursts are not interleaved.
  - The lock ends the first cycle its req_i or lock_i drops; round-robin resumes from ptr+1.
- Undefined: the port is absent and arbitration is pure round-robin.

Decomposition:
- Package fifo_arb_pkg holds:
  - localparam helper CNT_W = $clog2(depth+1).
  - Function rr_pick(req, ptr), returning the one-hot winner.
- One natural sub-module: rr_arbiter (combinational pick plus pointer register). The credit counter and push register stay in fifo_push_arb.

Test Plan:
- After reset release, req_i=4'b0001 with data 8'hAB: gnt_o[0] high one cycle, push_o=1 with push_data_o=8'hAB next cycle, occ_o=1.
- req_i=4'b1111 held, no pops, depth=4: grants to 0,1,2,3 in order, then gnt_o=0, occ_o=4, FIFO f_o=1, ovf_o=0.
- At occ=4, pulse fifo_pop_i once: occ_o=3 next cycle; the following grant goes to requester 0 (wrap).
- Simultaneous grant and pop at occ=2: occ_o stays 2; FIFO popped data matches first-pushed order (8'hAB then 8'hCC).
- Drive fifo_pop_i with fifo_e_i=1 and occ=0: occ_o stays 0, ovf_o stays 0. Then force push_o with fifo_f_i=1 via the bench FIFO model: ovf_o=1 and stays 1 until reset.
- FIFO_ARB_LOCK_EN: requester 2 holds lock_i and req_i for 3 cycles while all requesters request: three consecutive gnt_o[2]; then requester 3 is granted.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : fifo_arb_pkg
// Brief    : Shared constants and the round-robin pick function for the
//            FIFO push arbiter. Optional lock: FIFO_ARB_LOCK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

   localparam int MAX_REQ   = 32;
   localparam int IDX_W     = $clog2(MAX_REQ);
   localparam int DEF_DEPTH = 4;
   localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

   function automatic int cnt_width(input int d);
      return $clog2(d + 1);
   endfunction

   // One-hot winner: first set bit of req searching upward from ptr+1, mod n.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0] req,
      input int unsigned        ptr,
      input int unsigned        n = MAX_REQ
   );
      logic [MAX_REQ-1:0] onehot;
      logic               found;
      logic [IDX_W-1:0]   idx;
      onehot = '0;
      found  = 1'b0;
      for (int unsigned i = 1; i <= MAX_REQ; i++) begin
         if (i <= n) begin
            idx = IDX_W'((ptr + i) % n);
            if (!found && req[idx]) begin
               onehot[idx] = 1'b1;
               found       = 1'b1;
            end
         end
      end
      return onehot;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_push_arb_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick with a registered last-winner
//            pointer. Optional burst lock under FIFO_ARB_LOCK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int n_req = 4,
   localparam int c_ptr_w = (n_req > 1) ? $clog2(n_req) : 1
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [n_req-1:0] req,
`ifdef FIFO_ARB_LOCK_EN
   input  logic [n_req-1:0] lock,
`endif
   input  logic             enable,
   output logic [n_req-1:0] gnt
);

   logic [c_ptr_w-1:0] r_ptr;
   logic [MAX_REQ-1:0] w_pick;
   logic [n_req-1:0]   w_rr;
   logic [n_req-1:0]   w_sel;
   logic [c_ptr_w-1:0] w_win_idx;

   assign w_pick = rr_pick(MAX_REQ'(req), 32'(r_ptr), n_req);
   assign w_rr   = w_pick[n_req-1:0];

   generate
      if (n_req < MAX_REQ) begin : g_unused_pick
         logic w_unused_pick;
         assign w_unused_pick = ^w_pick[MAX_REQ-1:n_req];
      end
   endgenerate

`ifdef FIFO_ARB_LOCK_EN
   logic r_lock_live;
   logic w_lock_hit;

   // A lock only counts for the requester that won the previous grant.
   assign w_lock_hit = r_lock_live & req[r_ptr] & lock[r_ptr];
`endif

   always_comb begin
      w_sel = w_rr;
`ifdef FIFO_ARB_LOCK_EN
      if (w_lock_hit) begin
         w_sel        = '0;
         w_sel[r_ptr] = 1'b1;
      end
`endif
   end

   assign gnt = (enable && reset) ? w_sel : '0;

   always_comb begin
      w_win_idx = r_ptr;
      for (int i = 0; i < n_req; i++) begin
         if (w_sel[i]) w_win_idx = c_ptr_w'(i);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ptr       <= c_ptr_w'(n_req - 1);
`ifdef FIFO_ARB_LOCK_EN
         r_lock_live <= 1'b0;
`endif
      end else begin
         if (|gnt) r_ptr <= w_win_idx;
`ifdef FIFO_ARB_LOCK_EN
         r_lock_live <= (|gnt) ? 1'b1 : w_lock_hit;
`endif
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arb.sv
//------------------------------------------------------------------------------
// Module   : fifo_push_arb
// Brief    : Round-robin sharing of one FIFO push port with credit-based
//            occupancy tracking. Optional burst lock: FIFO_ARB_LOCK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_push_arb
   import fifo_arb_pkg::*;
#(
   parameter int data_w = 8,
   parameter int depth  = 4,
   parameter int n_req  = 4,
   localparam int c_occ_w = cnt_width(depth)
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic [n_req-1:0]        req_i,
   input  logic [n_req*data_w-1:0] req_data_i,
`ifdef FIFO_ARB_LOCK_EN
   input  logic [n_req-1:0]        lock_i,
`endif
   output logic [n_req-1:0]        gnt_o,
   output logic                    push_o,
   output logic [data_w-1:0]       push_data_o,
   input  logic                    fifo_pop_i,
   input  logic                    fifo_e_i,
   input  logic                    fifo_f_i,
   output logic [c_occ_w-1:0]      occ_o,
   output logic                    ovf_o
);

   logic [n_req-1:0]   w_gnt;
   logic               w_grant;
   logic               w_pop_ok;
   logic               w_credit_ok;
   logic               w_occ_zero;
   logic [data_w-1:0]  w_win_data;

   logic [c_occ_w-1:0] r_occ;
   logic               r_push;
   logic [data_w-1:0]  r_push_data;
   logic               r_ovf;

   // Credit includes the in-flight push, so a full count blocks grants
   // even while the FIFO itself still reports not-full.
   assign w_credit_ok = (r_occ < c_occ_w'(depth));
   assign w_occ_zero  = (r_occ == '0);
   assign w_pop_ok    = fifo_pop_i & ~fifo_e_i;

   rr_arbiter #(
      .n_req  (n_req)
   ) u_rr_arbiter (
      .clock  (clock),
      .reset  (reset),
      .req    (req_i),
`ifdef FIFO_ARB_LOCK_EN
      .lock   (lock_i),
`endif
      .enable (w_credit_ok),
      .gnt    (w_gnt)
   );

   assign w_grant = |w_gnt;

   always_comb begin
      w_win_data = '0;
      for (int k = 0; k < n_req; k++) begin
         if (w_gnt[k]) w_win_data = w_win_data | req_data_i[k*data_w +: data_w];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_occ       <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_push <= w_grant;
         if (w_grant) r_push_data <= w_win_data;

         case ({w_grant, w_pop_ok && !w_occ_zero})
            2'b10:   r_occ <= r_occ + c_occ_w'(1);
            2'b01:   r_occ <= r_occ - c_occ_w'(1);
            default: r_occ <= r_occ;
         endcase

         if ((r_push && fifo_f_i && !fifo_pop_i) || (w_pop_ok && w_occ_zero))
            r_ovf <= 1'b1;
      end
   end

   assign gnt_o       = w_gnt;
   assign push_o      = r_push;
   assign push_data_o = r_push_data;
   assign occ_o       = r_occ;
   assign ovf_o       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_push_arb
// Brief    : Directed vector bench for fifo_push_arb with a small FIFO model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_push_arb;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic        pop;
      logic [3:0]  lock;
      logic [3:0]  gnt;
      logic        push;
      logic [7:0]  pd;
      logic [2:0]  occ;
      logic        ovf;
   } vec_t;

   logic        clock;
   logic        reset;
   logic [3:0]  req_i;
   logic [31:0] req_data_i;
   logic [3:0]  gnt_o;
   logic        push_o;
   logic [7:0]  push_data_o;
   logic        fifo_pop_i;
   logic        fifo_e_i;
   logic        fifo_f_i;
   logic [2:0]  occ_o;
   logic        ovf_o;
`ifdef FIFO_ARB_LOCK_EN
   logic [3:0]  lock_i;
`endif

   int n_vec;
   int n_err;

   fifo_push_arb #(.data_w(8), .depth(4), .n_req(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_i       (req_i),
      .req_data_i  (req_data_i),
`ifdef FIFO_ARB_LOCK_EN
      .lock_i      (lock_i),
`endif
      .gnt_o       (gnt_o),
      .push_o      (push_o),
      .push_data_o (push_data_o),
      .fifo_pop_i  (fifo_pop_i),
      .fifo_e_i    (fifo_e_i),
      .fifo_f_i    (fifo_f_i),
      .occ_o       (occ_o),
      .ovf_o       (ovf_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Depth-4 FIFO model; force_f pins the full flag high to provoke overflow.
   logic [7:0] mem [4];
   logic [7:0] pop_log [16];
   logic [1:0] wp, rp;
   logic [2:0] cnt;
   logic [3:0] pop_cnt;
   logic       force_f;
   logic       do_pop, do_push;

   assign fifo_e_i = (cnt == 3'd0);
   assign fifo_f_i = (cnt == 3'd4) || force_f;
   assign do_pop   = fifo_pop_i && (cnt != 3'd0);
   assign do_push  = push_o && (cnt != 3'd4) && !force_f;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         wp <= 2'd0; rp <= 2'd0; cnt <= 3'd0; pop_cnt <= 4'd0;
      end else begin
         if (do_pop) begin
            pop_log[pop_cnt] <= mem[rp];
            pop_cnt          <= pop_cnt + 4'd1;
            rp               <= rp + 2'd1;
         end
         if (do_push) begin
            mem[wp] <= push_data_o;
            wp      <= wp + 2'd1;
         end
         cnt <= cnt + {2'b00, do_push} - {2'b00, do_pop};
      end
   end

   function automatic vec_t mk(input logic [3:0] req, input logic [31:0] data,
                               input logic pop, input logic [3:0] lock,
                               input logic [3:0] gnt, input logic push,
                               input logic [7:0] pd, input logic [2:0] occ,
                               input logic ovf);
      vec_t v;
      v.req = req; v.data = data; v.pop = pop; v.lock = lock;
      v.gnt = gnt; v.push = push; v.pd = pd; v.occ = occ; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string name, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input vec_t v);
      n_vec++;
      chk(name, "gnt",  32'(gnt_o),       32'(v.gnt));
      chk(name, "push", 32'(push_o),      32'(v.push));
      chk(name, "pd",   32'(push_data_o), 32'(v.pd));
      chk(name, "occ",  32'(occ_o),       32'(v.occ));
      chk(name, "ovf",  32'(ovf_o),       32'(v.ovf));
   endtask

   task automatic apply(input string name, input vec_t v);
      @(negedge clock);
      req_i      = v.req;
      req_data_i = v.data;
      fifo_pop_i = v.pop;
`ifdef FIFO_ARB_LOCK_EN
      lock_i     = v.lock;
`endif
      #1;
      check_outs(name, v);
   endtask

   // Reset with all requests high: grants must stay low while reset is held.
   task automatic do_reset(input string name);
      @(negedge clock);
      reset      = 1'b0;
      req_i      = 4'hF;
      req_data_i = 32'h5555_5555;
      fifo_pop_i = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
      lock_i     = 4'hF;
`endif
      #1;
      check_outs(name, mk(4'hF, 32'h5555_5555, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00, 3'd0, 1'b0));
      @(negedge clock);
      req_i   = 4'h0;
      force_f = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   vec_t tbl [8];
   localparam logic [31:0] c_fill = 32'h4332_2110;

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b0; force_f = 1'b0;
      req_i = 4'h0; req_data_i = 32'h0; fifo_pop_i = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
      lock_i = 4'h0;
`endif

      //            req     data          pop  lock  gnt     push pd     occ  ovf
      tbl[0] = mk(4'b0001, 32'h0000_00AB, 1'b0, 4'h0, 4'b0001, 1'b0, 8'h00, 3'd0, 1'b0);
      tbl[1] = mk(4'b0000, 32'h0000_0000, 1'b0, 4'h0, 4'b0000, 1'b1, 8'hAB, 3'd1, 1'b0);
      tbl[2] = mk(4'b0010, 32'h0000_CC00, 1'b0, 4'h0, 4'b0010, 1'b0, 8'hAB, 3'd1, 1'b0);
      tbl[3] = mk(4'b0001, 32'h0000_0011, 1'b1, 4'h0, 4'b0001, 1'b1, 8'hCC, 3'd2, 1'b0);
      tbl[4] = mk(4'b0000, 32'h0000_0000, 1'b1, 4'h0, 4'b0000, 1'b1, 8'h11, 3'd2, 1'b0);
      tbl[5] = mk(4'b0000, 32'h0000_0000, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h11, 3'd1, 1'b0);
      tbl[6] = mk(4'b0000, 32'h0000_0000, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h11, 3'd0, 1'b0);
      tbl[7] = mk(4'b0000, 32'h0000_0000, 1'b0, 4'h0, 4'b0000, 1'b0, 8'h11, 3'd0, 1'b0);

      do_reset("rst0");
      for (int i = 0; i < 8; i++) apply($sformatf("tbl%0d", i), tbl[i]);
      n_vec++; chk("order", "pop0", 32'(pop_log[0]), 32'h0000_00AB);
      n_vec++; chk("order", "pop1", 32'(pop_log[1]), 32'h0000_00CC);

      // Fill to depth with all requesters, then release one credit.
      do_reset("rst1");
      apply("fill0", mk(4'hF, c_fill, 1'b0, 4'h0, 4'b0001, 1'b0, 8'h00, 3'd0, 1'b0));
      apply("fill1", mk(4'hF, c_fill, 1'b0, 4'h0, 4'b0010, 1'b1, 8'h10, 3'd1, 1'b0));
      apply("fill2", mk(4'hF, c_fill, 1'b0, 4'h0, 4'b0100, 1'b1, 8'h21, 3'd2, 1'b0));
      apply("fill3", mk(4'hF, c_fill, 1'b0, 4'h0, 4'b1000, 1'b1, 8'h32, 3'd3, 1'b0));
      apply("fill4", mk(4'hF, c_fill, 1'b0, 4'h0, 4'b0000, 1'b1, 8'h43, 3'd4, 1'b0));
      apply("fill5", mk(4'hF, c_fill, 1'b0, 4'h0, 4'b0000, 1'b0, 8'h43, 3'd4, 1'b0));
      n_vec++; chk("fill5", "fifo_full", 32'(fifo_f_i), 32'd1);
      apply("popf0", mk(4'hF, c_fill, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h43, 3'd4, 1'b0));
      apply("popf1", mk(4'hF, c_fill, 1'b0, 4'h0, 4'b0001, 1'b0, 8'h43, 3'd3, 1'b0));
      apply("popf2", mk(4'h0, c_fill, 1'b0, 4'h0, 4'b0000, 1'b1, 8'h10, 3'd4, 1'b0));

      // Push into a FIFO that reports full: sticky overflow until reset.
      do_reset("rst2");
      force_f = 1'b1;
      apply("ovf0", mk(4'b0001, 32'h0000_005A, 1'b0, 4'h0, 4'b0001, 1'b0, 8'h00, 3'd0, 1'b0));
      apply("ovf1", mk(4'b0000, 32'h0000_0000, 1'b0, 4'h0, 4'b0000, 1'b1, 8'h5A, 3'd1, 1'b0));
      apply("ovf2", mk(4'b0000, 32'h0000_0000, 1'b0, 4'h0, 4'b0000, 1'b0, 8'h5A, 3'd1, 1'b1));
      apply("ovf3", mk(4'b0000, 32'h0000_0000, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h5A, 3'd1, 1'b1));
      apply("ovf4", mk(4'b0000, 32'h0000_0000, 1'b0, 4'h0, 4'b0000, 1'b0, 8'h5A, 3'd1, 1'b1));
      do_reset("rst3");

`ifdef FIFO_ARB_LOCK_EN
      apply("lock0", mk(4'hF, c_fill, 1'b1, 4'b0100, 4'b0001, 1'b0, 8'h00, 3'd0, 1'b0));
      apply("lock1", mk(4'hF, c_fill, 1'b1, 4'b0100, 4'b0010, 1'b1, 8'h10, 3'd1, 1'b0));
      apply("lock2", mk(4'hF, c_fill, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h21, 3'd2, 1'b0));
      apply("lock3", mk(4'hF, c_fill, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h32, 3'd2, 1'b0));
      apply("lock4", mk(4'hF, c_fill, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h32, 3'd2, 1'b0));
      apply("lock5", mk(4'hF, c_fill, 1'b1, 4'b0000, 4'b1000, 1'b1, 8'h32, 3'd2, 1'b0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
